// File: rtl/fifo_rr_scheduler_pkg.sv
// rtl/fifo_rr_scheduler_pkg.sv - shared state codes, dest field helpers and reset thresholds
`define FIFO_SCHED_DEST(word, ws, dw) word[(ws)-1 -: (dw)]

package fifo_sched_pkg;
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam int AE_RST = 2;
    localparam int AF_RST = 6;

    function automatic int dest_w(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction
endpackage

// File: rtl/fifo_rr_scheduler_arbiter.sv
// rtl/fifo_rr_scheduler_arbiter.sv - combinational round-robin arbiter, search starts after ptr
module rr_arbiter #(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [N_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);
    logic [IDX_W-1:0] idx;
    logic             found;

    // N_PORTS is a power of two, so the index wraps by truncation
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = ptr + IDX_W'(k);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                gnt_idx    = idx;
                gnt[idx]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - round-robin transfer of words from input FIFOs to output FIFOs
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int WORD_SIZE = 10,
    parameter int PTR_SIZE  = 3,
    parameter int DEST_W    = dest_w(N_PORTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic [PTR_SIZE-1:0]          ae_thr_in,
    input  logic [PTR_SIZE-1:0]          af_thr_in,
    input  logic [N_PORTS-1:0]           in_empty,
    input  logic [N_PORTS-1:0]           in_valid,
    input  logic [N_PORTS*WORD_SIZE-1:0] in_data,
    output logic [N_PORTS-1:0]           in_rd_en,
    input  logic [N_PORTS-1:0]           out_almost_full,
    input  logic [N_PORTS-1:0]           out_full,
    output logic [N_PORTS-1:0]           out_wr_en,
    output logic [WORD_SIZE-1:0]         out_data,
    output logic                         fifo_init,
    output logic [PTR_SIZE-1:0]          ae_thr,
    output logic [PTR_SIZE-1:0]          af_thr,
    output logic [2:0]                   state,
    output logic                         idle,
    output logic                         error
);
    state_t               st, st_nxt;
    logic [DEST_W-1:0]    rr_ptr, gnt_idx, pop_idx;
    logic [N_PORTS-1:0]   gnt;
    logic                 grant_en, drained, overflow, pop_d, s2_valid;
    logic [WORD_SIZE-1:0] pop_word, s2_data;
    logic [DEST_W-1:0]    s2_dest;

    assign grant_en = (st == S_ACTIVE) && !init && !(|out_almost_full);

    rr_arbiter #(.N_PORTS(N_PORTS), .IDX_W(DEST_W)) u_arb (
        .req     (~in_empty),
        .ptr     (rr_ptr),
        .enable  (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign pop_word = in_data[pop_idx*WORD_SIZE +: WORD_SIZE];
    assign drained  = !pop_d && !s2_valid;

    // a push colliding with full is still issued; ERROR only blocks what follows
    always_comb begin
        out_wr_en = '0;
        if (s2_valid && st != S_ERROR) out_wr_en[s2_dest] = 1'b1;
    end
    assign out_data = (|out_wr_en) ? s2_data : '0;
    assign overflow = |(out_wr_en & out_full);

    always_comb begin
        st_nxt = st;
        case (st)
            S_RESET:  st_nxt = S_INIT;
            S_INIT:   if (!init) st_nxt = S_IDLE;
            S_IDLE: begin
                if (init) st_nxt = S_INIT;
                else if (!(&in_empty) && !(|out_almost_full)) st_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (drained && init) st_nxt = S_INIT;
                else if (drained && (&in_empty)) st_nxt = S_IDLE;
            end
            S_ERROR:  st_nxt = S_ERROR;
            default:  st_nxt = S_RESET;
        endcase
        if (overflow) st_nxt = S_ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= S_RESET;
            rr_ptr   <= '1;
            pop_d    <= 1'b0;
            pop_idx  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_dest  <= '0;
            ae_thr   <= PTR_SIZE'(AE_RST);
            af_thr   <= PTR_SIZE'(AF_RST);
        end else begin
            st       <= st_nxt;
            pop_d    <= |gnt;
            if (|gnt) begin
                rr_ptr  <= gnt_idx;
                pop_idx <= gnt_idx;
            end
            s2_valid <= pop_d && in_valid[pop_idx];
            if (pop_d && in_valid[pop_idx]) begin
                s2_data <= pop_word;
                s2_dest <= `FIFO_SCHED_DEST(pop_word, WORD_SIZE, DEST_W);
            end
            if (st == S_INIT) begin
                ae_thr <= ae_thr_in;
                af_thr <= af_thr_in;
            end
        end
    end

    assign in_rd_en  = gnt;
    assign fifo_init = (st == S_INIT);
    assign idle      = (st == S_IDLE);
    assign error     = (st == S_ERROR);
    assign state     = st;
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb/tb_fifo_rr_scheduler.sv - queue-backed FIFO models and scoreboard around fifo_rr_scheduler
module tb_fifo_rr_scheduler;
    localparam int N = 4;
    localparam int W = 10;
    localparam int P = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, init;
    logic [P-1:0]     ae_thr_in, af_thr_in, ae_thr, af_thr;
    logic [N-1:0]     in_empty, in_valid, in_rd_en, out_almost_full, out_full, out_wr_en;
    logic [N*W-1:0]   in_data;
    logic [W-1:0]     out_data;
    logic             fifo_init, idle, error;
    logic [2:0]       state;

    fifo_rr_scheduler dut (
        .clk(clk), .reset(reset), .init(init), .ae_thr_in(ae_thr_in), .af_thr_in(af_thr_in),
        .in_empty(in_empty), .in_valid(in_valid), .in_data(in_data), .in_rd_en(in_rd_en),
        .out_almost_full(out_almost_full), .out_full(out_full), .out_wr_en(out_wr_en),
        .out_data(out_data), .fifo_init(fifo_init), .ae_thr(ae_thr), .af_thr(af_thr),
        .state(state), .idle(idle), .error(error)
    );

    typedef struct { int c; logic [W-1:0] d; } exp_t;

    int checks = 0, failures = 0;
    logic c_reset = 1'b1, c_init = 1'b0;
    logic [P-1:0] c_ae = '0, c_af = '0;
    logic [N-1:0] c_afl = '0, c_full = '0;
    logic [W-1:0] q[N][$];
    logic [N-1:0] pres_v = '0;
    logic [W-1:0] pres_d[N];
    exp_t exp_q[$];
    int pop_port[$], pop_cyc[$];
    int cyc = 0, mptr = N - 1, push_cnt = 0, drop_pct = 0;
    bit sb_on = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int left();
        int s = 0;
        for (int i = 0; i < N; i++) s += q[i].size();
        return s;
    endfunction

    // Grant expectation: first non-empty bench FIFO after the last granted port
    task automatic check_cycle();
        int g;
        logic [W-1:0] w;
        exp_t e;
        if (in_rd_en != '0) begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && q[(mptr + k) % N].size() != 0) g = (mptr + k) % N;
            chk("pop_gate", {init, |out_almost_full}, 2'b00);
            chk("pop_rr", in_rd_en, (g < 0) ? 64'd0 : (64'd1 << g));
            if (g >= 0) begin
                w = q[g].pop_front();
                pres_v[g] = ($urandom_range(99) >= drop_pct);
                pres_d[g] = w;
                if (pres_v[g]) exp_q.push_back('{c: cyc + 2, d: w});
                pop_port.push_back(g);
                pop_cyc.push_back(cyc);
                mptr = g;
            end
        end
        if (exp_q.size() != 0 && exp_q[0].c == cyc) begin
            e = exp_q.pop_front();
            chk("push_en", out_wr_en, 64'd1 << e.d[W-1 -: 2]);
            chk("push_data", out_data, e.d);
            push_cnt++;
        end else begin
            chk("no_push", out_wr_en, 0);
        end
    endtask

    // Inputs change 1 time unit after posedge, outputs are sampled at negedge
    task automatic tick();
        @(posedge clk);
        #1;
        reset = c_reset; init = c_init; ae_thr_in = c_ae; af_thr_in = c_af;
        out_almost_full = c_afl; out_full = c_full;
        for (int i = 0; i < N; i++) begin
            in_empty[i] = (q[i].size() == 0);
            in_valid[i] = pres_v[i];
            in_data[i*W +: W] = pres_v[i] ? pres_d[i] : W'($urandom);
        end
        pres_v = '0;
        @(negedge clk);
        cyc++;
        if (sb_on) check_cycle();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(state == 3'd2 && left() == 0 && exp_q.size() == 0) && n < 80) begin
            tick();
            n++;
        end
        chk(tag, state, 3'd2);
        chk({tag, "_left"}, left() + exp_q.size(), 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) q[i].delete();
        exp_q.delete();
        pop_port.delete();
        pop_cyc.delete();
        pres_v = '0;
        mptr = N - 1;
    endtask

    task automatic run_pops(input int target);
        int n = 0;
        while (pop_port.size() < target && n < 30) begin
            tick();
            n++;
        end
        chk("pops_started", pop_port.size() >= target, 1);
    endtask

    initial begin
        int n0, p0;
        // reset and configuration
        c_reset = 1'b1;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_strobes", {in_rd_en, out_wr_en, fifo_init, idle, error}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_thr", {ae_thr, af_thr}, {3'd2, 3'd6});
        c_reset = 1'b0; c_init = 1'b1; c_ae = 3'd1; c_af = 3'd5;
        tick(); chk("seq_reset", state, 0);
        tick(); chk("seq_init", state, 1); chk("fifo_init_hi", fifo_init, 1);
        tick(); chk("seq_init2", state, 1);
        c_init = 1'b0;
        tick(); chk("seq_init_exit", state, 1);
        tick(); chk("seq_idle", state, 2); chk("idle_hi", {idle, fifo_init}, 2'b10);
        chk("cfg_thr", {ae_thr, af_thr}, {3'd1, 3'd5});

        // all ports, two words each, dest 0
        sb_on = 1'b1;
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 2; k++) q[p].push_back({2'b00, 8'(p * 16 + k)});
        pop_port.delete(); pop_cyc.delete(); push_cnt = 0;
        drain("t2_idle");
        chk("t2_npops", pop_port.size(), 8);
        for (int i = 0; i < pop_port.size(); i++) begin
            chk("t2_order", pop_port[i], i % 4);
            chk("t2_consec", pop_cyc[i] - pop_cyc[0], i);
        end
        chk("t2_npush", push_cnt, 8);

        // single port, dest 3
        q[2].push_back(10'h3C1); q[2].push_back(10'h3C2);
        pop_port.delete(); pop_cyc.delete(); push_cnt = 0;
        drain("t3_idle");
        chk("t3_npops", pop_port.size(), 2);
        for (int i = 0; i < pop_port.size(); i++) begin
            chk("t3_port", pop_port[i], 2);
            chk("t3_consec", pop_cyc[i] - pop_cyc[0], i);
        end
        chk("t3_npush", push_cnt, 2);

        // almost-full back-pressure mid-stream
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 4; k++) q[p].push_back(W'($urandom));
        pop_port.delete(); pop_cyc.delete();
        run_pops(3);
        c_afl = 4'b0010; p0 = push_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_stall", in_rd_en, 0);
        end
        chk("bp_inflight", (push_cnt - p0) <= 2, 1);
        chk("bp_active", state, 3);
        c_afl = '0; n0 = pop_port.size();
        tick();
        chk("bp_resume", pop_port.size() - n0, 1);
        drain("t4_idle");

        // randomized traffic with almost-full pulses and dropped words
        drop_pct = 12;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(2) == 0) begin
                n0 = $urandom_range(N - 1);
                if (q[n0].size() < 6) q[n0].push_back(W'($urandom));
            end
            c_afl = ($urandom_range(5) == 0) ? N'(1 << $urandom_range(N - 1)) : '0;
            tick();
        end
        c_afl = '0; drop_pct = 0;
        drain("rand_idle");

        // init while active
        for (int k = 0; k < 3; k++) begin
            q[0].push_back(W'($urandom));
            q[1].push_back(W'($urandom));
        end
        pop_port.delete(); pop_cyc.delete();
        run_pops(2);
        c_init = 1'b1; n0 = pop_port.size();
        for (int i = 0; i < 10 && state != 3'd1; i++) tick();
        chk("init_enter", state, 1);
        chk("init_nopop", pop_port.size() - n0, 0);
        chk("init_drained", exp_q.size(), 0);
        chk("init_fifo_init", fifo_init, 1);
        c_init = 1'b0;
        drain("t5_idle");

        // overflow into ERROR
        c_full = 4'b0100; p0 = push_cnt;
        q[0].push_back(10'h2AA);
        for (int i = 0; i < 10 && push_cnt == p0; i++) tick();
        chk("ovf_wr", out_wr_en, 4'b0100);
        tick();
        chk("ovf_state", state, 4);
        chk("ovf_error", error, 1);
        q[1].push_back(10'h011); q[3].push_back(10'h022);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_strobes", {in_rd_en, out_wr_en, fifo_init, idle}, 0);
            chk("err_sticky", {state, error}, {3'd4, 1'b1});
        end
        c_full = '0;

        // reset out of ERROR, then reset mid-stream
        sb_on = 1'b0; c_reset = 1'b1;
        tick(); tick();
        clear_model();
        chk("err_rst_state", state, 0);
        c_reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rerun_idle", state, 2);
        sb_on = 1'b1;
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 3; k++) q[p].push_back(W'($urandom));
        run_pops(3);
        sb_on = 1'b0; c_reset = 1'b1;
        tick(); tick();
        chk("mid_rst_state", state, 0);
        chk("mid_rst_strobes", {in_rd_en, out_wr_en, fifo_init, idle, error}, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_thr", {ae_thr, af_thr}, {3'd2, 3'd6});
        clear_model();
        c_reset = 1'b0; sb_on = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_idle", state, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
